// File: rtl/score_bcd_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | score_bcd_counter: packed-BCD game score with IDLE/PLAY/OVER state,       |
// | saturation at all nines, optional high score (macro HIGH_SCORE_EN).       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module score_bcd_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  new_game,
  input  logic                  step_in,
  input  logic                  bonus_in,
  input  logic                  game_over,
  output logic                  playing,
  output logic [4*DIGITS-1:0]   score_digits,
  output logic [4*DIGITS-1:0]   high_digits,
  output logic                  new_high,
  output logic                  saturated
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam logic [4*DIGITS-1:0] C_ALL_NINES = {DIGITS{4'h9}};

  logic [1:0]            r_state;
  logic                  r_playing;
  logic                  r_saturated;
  logic                  r_step_prev;
  logic                  r_bonus_prev;
  logic [4*DIGITS-1:0]   r_score;

  logic                  w_step_evt;
  logic                  w_bonus_evt;
  logic [2:0]            w_amt;
  logic [3:0]            w_carry;
  logic [4:0]            w_dsum;
  logic [4*DIGITS-1:0]   w_sum;
  logic                  w_cout;

  assign w_step_evt  = step_in & ~r_step_prev;
  assign w_bonus_evt = bonus_in & ~r_bonus_prev;
  assign w_amt       = (w_step_evt ? 3'd1 : 3'd0) + (w_bonus_evt ? 3'd5 : 3'd0);

  // Ripple BCD add of 0..6 into the low digit; carry out of the top digit saturates.
  always_comb begin
    w_carry = {1'b0, w_amt};
    w_dsum  = '0;
    w_sum   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_dsum = {1'b0, r_score[4*i +: 4]} + {1'b0, w_carry};
      if (w_dsum > 5'd9) begin
        w_sum[4*i +: 4] = w_dsum[3:0] - 4'd10;
        w_carry         = 4'd1;
      end else begin
        w_sum[4*i +: 4] = w_dsum[3:0];
        w_carry         = 4'd0;
      end
    end
    w_cout = (w_carry != 4'd0);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_playing    <= 1'b0;
      r_saturated  <= 1'b0;
      r_step_prev  <= 1'b0;
      r_bonus_prev <= 1'b0;
      r_score      <= '0;
    end else begin
      r_step_prev  <= step_in;
      r_bonus_prev <= bonus_in;
      if (new_game) begin
        r_state     <= S_PLAY;
        r_playing   <= 1'b1;
        r_score     <= '0;
        r_saturated <= 1'b0;
      end else if (r_state == S_PLAY) begin
        if (game_over) begin
          r_state   <= S_OVER;
          r_playing <= 1'b0;
        end else if (w_step_evt || w_bonus_evt) begin
          if (w_cout) begin
            r_score     <= C_ALL_NINES;
            r_saturated <= 1'b1;
          end else begin
            r_score <= w_sum;
          end
        end
      end
    end
  end

`ifdef HIGH_SCORE_EN
  logic [4*DIGITS-1:0] r_high;
  logic                r_new_high;

  // Straight unsigned compare is exact for valid packed BCD.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_high     <= '0;
      r_new_high <= 1'b0;
    end else if (new_game) begin
      r_new_high <= 1'b0;
    end else if ((r_state == S_PLAY) && game_over && (r_score > r_high)) begin
      r_high     <= r_score;
      r_new_high <= 1'b1;
    end
  end

  assign high_digits = r_high;
  assign new_high    = r_new_high;
`else
  assign high_digits = '0;
  assign new_high    = 1'b0;
`endif

  assign playing      = r_playing;
  assign score_digits = r_score;
  assign saturated    = r_saturated;

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_counter.sv
`default_nettype none
// Directed, table-driven bench for score_bcd_counter plus hand-written
// multi-cycle sequences (saturation, game over, async reset).
module tb_score_bcd_counter;

`ifdef HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        new_game = 1'b0;
  logic        step_in = 1'b0;
  logic        bonus_in = 1'b0;
  logic        game_over = 1'b0;
  logic        playing;
  logic [15:0] score_digits;
  logic [15:0] high_digits;
  logic        new_high;
  logic        saturated;

  int checks = 0;
  int errors = 0;

  score_bcd_counter #(.DIGITS(4)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .new_game     (new_game),
    .step_in      (step_in),
    .bonus_in     (bonus_in),
    .game_over    (game_over),
    .playing      (playing),
    .score_digits (score_digits),
    .high_digits  (high_digits),
    .new_high     (new_high),
    .saturated    (saturated)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ng;
    logic        st;
    logic        bo;
    logic        go;
    logic [15:0] score;
    logic        play;
    logic        sat;
    logic [15:0] high;
    logic        nh;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [15:0] eh(input logic [15:0] v);
    return HS ? v : 16'h0000;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ng, input logic st, input logic bo, input logic go);
    new_game  = ng;
    step_in   = st;
    bonus_in  = bo;
    game_over = go;
  endtask

  task automatic pulse(input logic st, input logic bo);
    drive(1'b0, st, bo, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic start_game();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    //         ng  st  bo  go  score     pl  sat high      nh
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,16'h0001,1'b1,1'b0,16'h0000,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,16'h0001,1'b1,1'b0,16'h0000,1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,16'h0007,1'b1,1'b0,16'h0000,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,16'h0007,1'b1,1'b0,16'h0000,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,16'h0007,1'b1,1'b0,16'h0000,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b0,16'h0012,1'b1,1'b0,16'h0000,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b0,16'h0013,1'b1,1'b0,16'h0000,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,16'h0013,1'b1,1'b0,16'h0000,1'b0};
    vecs[9]  = '{1'b0,1'b1,1'b1,1'b0,16'h0019,1'b1,1'b0,16'h0000,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,16'h0019,1'b1,1'b0,16'h0000,1'b0};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0,16'h0020,1'b1,1'b0,16'h0000,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1,16'h0020,1'b0,1'b0,16'h0020,1'b1};
    vecs[13] = '{1'b0,1'b1,1'b1,1'b0,16'h0020,1'b0,1'b0,16'h0020,1'b1};
    vecs[14] = '{1'b1,1'b1,1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0020,1'b0};
    vecs[15] = '{1'b0,1'b1,1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0020,1'b0};

    // Reset state
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b0;
    tick();
    tick();
    check("reset_score", score_digits, 16'h0000);
    check("reset_playing", {15'd0, playing}, 16'd0);
    check("reset_high", high_digits, 16'h0000);
    check("reset_new_high", {15'd0, new_high}, 16'd0);
    check("reset_saturated", {15'd0, saturated}, 16'd0);
    #3 resetn = 1'b1;
    tick();
    pulse(1'b1, 1'b1);
    check("idle_ignores_events", score_digits, 16'h0000);

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].ng, vecs[i].st, vecs[i].bo, vecs[i].go);
      tick();
      check($sformatf("vec%0d_score", i), score_digits, vecs[i].score);
      check($sformatf("vec%0d_playing", i), {15'd0, playing}, {15'd0, vecs[i].play});
      check($sformatf("vec%0d_sat", i), {15'd0, saturated}, {15'd0, vecs[i].sat});
      check($sformatf("vec%0d_high", i), high_digits, eh(vecs[i].high));
      check($sformatf("vec%0d_new_high", i), {15'd0, new_high}, {15'd0, HS & vecs[i].nh});
    end

    // Fresh reset, twelve separate step edges
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    #2 resetn = 1'b1;
    tick();
    start_game();
    for (int i = 0; i < 12; i++) pulse(1'b1, 1'b0);
    check("twelve_steps", score_digits, 16'h0012);
    check("twelve_playing", {15'd0, playing}, 16'd1);
    check("twelve_sat", {15'd0, saturated}, 16'd0);

    // Held level counts once
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("held_step_once", score_digits, 16'h0013);

    // 8 + 6 carries into digit 1
    start_game();
    for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0);
    check("eight", score_digits, 16'h0008);
    pulse(1'b1, 1'b1);
    check("carry_0014", score_digits, 16'h0014);

    // Climb to 9997, then saturate
    start_game();
    for (int i = 0; i < 1666; i++) pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    check("preload_9997", score_digits, 16'h9997);
    check("preload_not_sat", {15'd0, saturated}, 16'd0);
    pulse(1'b0, 1'b1);
    check("sat_score", score_digits, 16'h9999);
    check("sat_flag", {15'd0, saturated}, 16'd1);
    pulse(1'b1, 1'b0);
    check("sat_hold", score_digits, 16'h9999);
    check("sat_hold_flag", {15'd0, saturated}, 16'd1);

    // Game over: first establish high 0x0030, then beat it with 0x0042
    start_game();
    check("ng_clears_sat", {15'd0, saturated}, 16'd0);
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b1);
    check("score_30", score_digits, 16'h0030);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("high_30", high_digits, eh(16'h0030));
    start_game();
    check("ng_high_kept", high_digits, eh(16'h0030));
    check("ng_new_high_clr", {15'd0, new_high}, 16'd0);
    for (int i = 0; i < 7; i++) pulse(1'b1, 1'b1);
    check("score_42", score_digits, 16'h0042);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("over_score", score_digits, 16'h0042);
    check("over_playing", {15'd0, playing}, 16'd0);
    check("over_high", high_digits, eh(16'h0042));
    check("over_new_high", {15'd0, new_high}, {15'd0, HS});
    tick();
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1);
    check("over_frozen", score_digits, 16'h0042);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("over_ng_score", score_digits, 16'h0000);
    check("over_ng_new_high", {15'd0, new_high}, 16'd0);
    check("over_ng_high", high_digits, eh(16'h0042));
    check("over_ng_playing", {15'd0, playing}, 16'd1);

    // Async reset mid-PLAY
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
    check("pre_reset_score", score_digits, 16'h0003);
    #2 resetn = 1'b0;
    #1;
    check("async_score", score_digits, 16'h0000);
    check("async_playing", {15'd0, playing}, 16'd0);
    check("async_high", high_digits, 16'h0000);
    #2 resetn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1);
    check("post_reset_idle", score_digits, 16'h0000);
    check("post_reset_playing", {15'd0, playing}, 16'd0);
    start_game();
    pulse(1'b1, 1'b0);
    check("post_reset_play", score_digits, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
